// File: rtl/pc_sequencer.sv
// Fetch-PC generator: selects exception, branch, jump, deferred-redirect or sequential next PC,
// defers redirects that arrive during a stall, and rejects misaligned targets to the exception vector.
module pc_sequencer #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0,
  parameter logic [XLEN-1:0] EXC_VECTOR   = 32'h80,
  parameter int              PC_STEP      = 4,
  parameter int              ALIGN_BITS   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            exc_en,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump_en,
  input  logic [XLEN-1:0] jump_target,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            flush,
  output logic            misalign_err,
  output logic            redirect_pending
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Built as a mask so ALIGN_BITS = 0 (no alignment requirement) stays legal.
  localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);
  localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic            pend_br_q, pend_br_d;
  logic            flush_q, flush_d;
  logic            mis_q, mis_d;

  logic            apply;
  logic [XLEN-1:0] target;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d   = state_q;
    pc_d      = pc_q;
    pend_d    = pend_q;
    pend_br_d = pend_br_q;
    flush_d   = 1'b0;
    mis_d     = 1'b0;
    apply     = 1'b0;
    target    = pend_q;

    if (exc_en) begin
      pc_d      = EXC_VECTOR;
      flush_d   = 1'b1;
      state_d   = RUN;
      pend_d    = '0;
      pend_br_d = 1'b0;
    end else begin
      unique case (state_q)
        BOOT: state_d = RUN;

        RUN: begin
          if (stall) begin
            if (branch_taken) begin
              pend_d    = branch_target;
              pend_br_d = 1'b1;
              state_d   = HOLD;
            end else if (jump_en) begin
              pend_d    = jump_target;
              pend_br_d = 1'b0;
              state_d   = HOLD;
            end
          end else if (branch_taken) begin
            apply  = 1'b1;
            target = branch_target;
          end else if (jump_en) begin
            apply  = 1'b1;
            target = jump_target;
          end else begin
            pc_d = pc_q + STEP;
          end
        end

        HOLD: begin
          if (stall) begin
            // A jump never displaces a deferred branch; a branch displaces anything.
            if (branch_taken) begin
              pend_d    = branch_target;
              pend_br_d = 1'b1;
            end else if (jump_en && !pend_br_q) begin
              pend_d = jump_target;
            end
          end else begin
            apply     = 1'b1;
            target    = branch_taken ? branch_target :
                        jump_en      ? jump_target   : pend_q;
            state_d   = RUN;
            pend_br_d = 1'b0;
          end
        end

        default: state_d = BOOT;
      endcase
    end

    if (apply) begin
      flush_d = 1'b1;
      if ((target & ALIGN_MASK) != '0) begin
        pc_d  = EXC_VECTOR;
        mis_d = 1'b1;
      end else begin
        pc_d = target;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= BOOT;
      pc_q      <= RESET_VECTOR;
      // NOTE: the pending target is reset too, so a discarded redirect can never leak out after reset.
      pend_q    <= '0;
      pend_br_q <= 1'b0;
      flush_q   <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      pend_br_q <= pend_br_d;
      flush_q   <= flush_d;
      mis_q     <= mis_d;
    end
  end

  assign pc               = pc_q;
  assign pc_valid         = (state_q != BOOT);
  assign flush            = flush_q;
  assign misalign_err     = mis_q;
  assign redirect_pending = (state_q == HOLD);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: vector table through a scoreboard queue,
// plus hand-written asynchronous-reset and boot-cycle sequences.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        exc_en = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump_en = 1'b0;
  logic [31:0] jump_target = '0;
  logic [31:0] pc;
  logic        pc_valid, flush, misalign_err, redirect_pending;

  int tests  = 0;
  int failed = 0;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .exc_en(exc_en),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump_en(jump_en), .jump_target(jump_target),
    .pc(pc), .pc_valid(pc_valid), .flush(flush),
    .misalign_err(misalign_err), .redirect_pending(redirect_pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        v, f, m, p;
  } exp_t;

  typedef struct {
    logic        stall, exc, br;
    logic [31:0] bt;
    logic        j;
    logic [31:0] jt;
    exp_t        e;
  } vec_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check({tag, ".pc"}, pc, e.pc);
    check({tag, ".pc_valid"}, 32'(pc_valid), 32'(e.v));
    check({tag, ".flush"}, 32'(flush), 32'(e.f));
    check({tag, ".misalign_err"}, 32'(misalign_err), 32'(e.m));
    check({tag, ".redirect_pending"}, 32'(redirect_pending), 32'(e.p));
  endtask

  function automatic void add(input logic s, input logic x, input logic b, input logic [31:0] bt,
                              input logic j, input logic [31:0] jt, input logic [31:0] epc,
                              input logic ev, input logic ef, input logic em, input logic ep);
    vec_t v;
    v.stall = s; v.exc = x; v.br = b; v.bt = bt; v.j = j; v.jt = jt;
    v.e = '{pc: epc, v: ev, f: ef, m: em, p: ep};
    vecs.push_back(v);
  endfunction

  // Called at a negedge: drive, push expectation, let the edge happen, compare, return at next negedge.
  task automatic step(input string tag, input vec_t v);
    exp_t got;
    stall = v.stall; exc_en = v.exc;
    branch_taken = v.br; branch_target = v.bt;
    jump_en = v.j; jump_target = v.jt;
    sb.push_back(v.e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check_all(tag, got);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //   stall exc br  bt            j   jt            pc            v  f  m  p
    add(0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 0, 0, 0); // boot cycle
    add(0, 0, 0, 32'h0,        0, 32'h0,        32'h4,        1, 0, 0, 0);
    add(0, 0, 0, 32'h0,        0, 32'h0,        32'h8,        1, 0, 0, 0);
    add(0, 0, 1, 32'h10,       0, 32'h0,        32'h10,       1, 1, 0, 0);
    add(0, 0, 1, 32'h40,       0, 32'h0,        32'h40,       1, 1, 0, 0);
    add(0, 0, 0, 32'h0,        0, 32'h0,        32'h44,       1, 0, 0, 0);
    add(0, 0, 0, 32'h0,        1, 32'h20,       32'h20,       1, 1, 0, 0);
    add(1, 0, 0, 32'h0,        1, 32'h100,      32'h20,       1, 0, 0, 1); // jump deferred
    add(1, 0, 1, 32'h200,      0, 32'h0,        32'h20,       1, 0, 0, 1); // branch overwrites
    add(1, 0, 0, 32'h0,        1, 32'h300,      32'h20,       1, 0, 0, 1); // jump must not overwrite
    add(1, 0, 0, 32'h0,        0, 32'h0,        32'h20,       1, 0, 0, 1);
    add(0, 0, 0, 32'h0,        0, 32'h0,        32'h200,      1, 1, 0, 0); // release
    add(0, 0, 0, 32'h0,        0, 32'h0,        32'h204,      1, 0, 0, 0);
    add(0, 0, 0, 32'h0,        1, 32'h30,       32'h30,       1, 1, 0, 0);
    add(1, 0, 1, 32'h500,      0, 32'h0,        32'h30,       1, 0, 0, 1);
    add(1, 1, 0, 32'h0,        0, 32'h0,        32'h80,       1, 1, 0, 0); // exc overrides stall
    add(1, 0, 0, 32'h0,        0, 32'h0,        32'h80,       1, 0, 0, 0);
    add(0, 0, 0, 32'h0,        0, 32'h0,        32'h84,       1, 0, 0, 0); // pending really gone
    add(0, 0, 1, 32'h42,       0, 32'h0,        32'h80,       1, 1, 1, 0); // misaligned branch
    add(0, 0, 0, 32'h0,        0, 32'h0,        32'h84,       1, 0, 0, 0);
    add(1, 0, 0, 32'h0,        1, 32'h106,      32'h84,       1, 0, 0, 1);
    add(0, 0, 0, 32'h0,        0, 32'h0,        32'h80,       1, 1, 1, 0); // misaligned on release
    add(0, 0, 0, 32'h0,        0, 32'h0,        32'h84,       1, 0, 0, 0);
    add(1, 0, 0, 32'h0,        1, 32'h600,      32'h84,       1, 0, 0, 1);
    add(0, 0, 1, 32'h700,      0, 32'h0,        32'h700,      1, 1, 0, 0); // new branch beats pending
    add(0, 0, 0, 32'h0,        0, 32'h0,        32'h704,      1, 0, 0, 0);
    add(1, 0, 0, 32'h0,        0, 32'h0,        32'h704,      1, 0, 0, 0); // plain stall holds
    add(0, 0, 0, 32'h0,        1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 1, 0, 0);
    add(0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 0, 0, 0); // wrap, no flag
    add(0, 0, 0, 32'h0,        0, 32'h0,        32'h4,        1, 0, 0, 0);
    add(0, 0, 0, 32'h0,        1, 32'h1001,     32'h80,       1, 1, 1, 0); // misaligned jump
    add(1, 0, 0, 32'h0,        1, 32'h900,      32'h80,       1, 0, 0, 1); // leave in HOLD

    #1;
    check_all("reset", '{pc: 32'h0, v: 1'b0, f: 1'b0, m: 1'b0, p: 1'b0});
    @(negedge clk);
    reset = 1'b0;
    foreach (vecs[i]) step($sformatf("vec%0d", i), vecs[i]);

    // Asynchronous reset while in HOLD, checked between clock edges.
    #2 reset = 1'b1;
    #1 check_all("async_reset", '{pc: 32'h0, v: 1'b0, f: 1'b0, m: 1'b0, p: 1'b0});
    @(negedge clk);
    reset = 1'b0;
    // Boot cycle ignores stall and branch; afterwards they take effect.
    step("boot_ignore", '{stall: 1, exc: 0, br: 1, bt: 32'h40, j: 0, jt: 32'h0,
                          e: '{pc: 32'h0, v: 1, f: 0, m: 0, p: 0}});
    step("post_boot_stall", '{stall: 1, exc: 0, br: 1, bt: 32'h40, j: 0, jt: 32'h0,
                              e: '{pc: 32'h0, v: 1, f: 0, m: 0, p: 1}});
    step("post_boot_release", '{stall: 0, exc: 0, br: 0, bt: 32'h0, j: 0, jt: 32'h0,
                                e: '{pc: 32'h40, v: 1, f: 1, m: 0, p: 0}});

    // Exception taken in the boot cycle.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    step("boot_exc", '{stall: 1, exc: 1, br: 0, bt: 32'h0, j: 0, jt: 32'h0,
                       e: '{pc: 32'h80, v: 1, f: 1, m: 0, p: 0}});
    step("boot_exc_next", '{stall: 0, exc: 0, br: 0, bt: 32'h0, j: 0, jt: 32'h0,
                            e: '{pc: 32'h84, v: 1, f: 0, m: 0, p: 0}});

    if (sb.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_drain: got %0d left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
